// File: rtl/drain.sv
// Write-back engine: captures row buffers from the PE array and streams them,
// four elements per word, into the result RAM with pause/resume at the RAM end.
module drain #(
  parameter int BIT_WIDTH      = 8,
  parameter int BUFFER_SZ      = 32,
  parameter int INDEX_WIDTH    = 6,
  parameter int ARRAY_DIM      = 32,
  parameter int DIM_WIDTH      = 5,
  parameter int STREAM_WIDTH   = 32,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 4096,
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic [STREAM_WIDTH-1:0]                   out_length,
  input  logic [RAM_ADDR_WIDTH-1:0]                 start_waddr,
  input  logic [ARRAY_DIM-1:0]                      pe_en,
  input  logic [BUFFER_SZ*ARRAY_DIM*BIT_WIDTH-1:0]  in_buffer,
  input  logic [INDEX_WIDTH-1:0]                    in_count,
  input  logic                                      in_valid,
  input  logic                                      resume,
  output logic                                      popped,
  output logic                                      started,
  output logic                                      busy,
  output logic                                      pause,
  output logic                                      done,
  output logic                                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]                 waddr,
  output logic [RAM_WIDTH-1:0]                      dout
);

  localparam int BUF_W = BUFFER_SZ * ARRAY_DIM * BIT_WIDTH;
  localparam int OFF_W = $clog2(BUF_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [DIM_WIDTH-1:0] words_per_row(input logic [ARRAY_DIM-1:0] en);
    logic [DIM_WIDTH-1:0] w;
    w = DIM_WIDTH'(1);
    for (int g = 0; g < ARRAY_DIM / 4; g++) begin
      if (en[4*g +: 4] != 4'd0) w = DIM_WIDTH'(g + 1);
    end
    return w;
  endfunction

  logic [2:0]                state_q, state_d;
  logic [STREAM_WIDTH-1:0]   len_q, len_d, rows_written_q, rows_written_d, remaining_s;
  logic [RAM_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d, waddr_q, waddr_d;
  logic [DIM_WIDTH-1:0]      words_q, words_d, word_q, word_d, cur_word_s;
  logic [INDEX_WIDTH-1:0]    row_q, row_d, rows_this_q, rows_this_d;
  logic [INDEX_WIDTH-1:0]    cur_row_s, cur_rows_s, count_eff_s, rows_new_s;
  logic [BUF_W-1:0]          shadow_q, shadow_d, src_s;
  logic [OFF_W-1:0]          off_s;
  logic [RAM_WIDTH-1:0]      word_s, dout_q, dout_d;
  logic ram_we_q, ram_we_d, popped_q, popped_d, started_q, started_d;
  logic done_q, done_d, pause_q, pause_d, busy_q, busy_d;
  logic emit_s, last_word_s, last_buf_s, job_end_s;

  // Next-state logic: FSM control plus the shared word-emission path
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rows_written_d = rows_written_q;
    base_d         = base_q;
    addr_d         = addr_q;
    words_d        = words_q;
    word_d         = word_q;
    row_d          = row_q;
    rows_this_d    = rows_this_q;
    shadow_d       = shadow_q;
    waddr_d        = waddr_q;
    dout_d         = dout_q;
    ram_we_d       = 1'b0;
    popped_d       = 1'b0;
    started_d      = 1'b0;
    done_d         = 1'b0;
    pause_d        = pause_q;
    busy_d         = busy_q;
    emit_s         = 1'b0;
    cur_row_s      = row_q;
    cur_word_s     = word_q;
    cur_rows_s     = rows_this_q;
    src_s          = shadow_q;

    remaining_s = len_q - rows_written_q;
    if ((in_count == INDEX_WIDTH'(0)) || (in_count > INDEX_WIDTH'(BUFFER_SZ))) begin
      count_eff_s = INDEX_WIDTH'(BUFFER_SZ);
    end else begin
      count_eff_s = in_count;
    end
    if (remaining_s < STREAM_WIDTH'(count_eff_s)) begin
      rows_new_s = INDEX_WIDTH'(remaining_s);
    end else begin
      rows_new_s = count_eff_s;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d          = out_length;
          base_d         = start_waddr;
          addr_d         = start_waddr;
          words_d        = words_per_row(pe_en);
          rows_written_d = STREAM_WIDTH'(0);
          started_d      = 1'b1;
          busy_d         = 1'b1;
          if (out_length == STREAM_WIDTH'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // The edge right after a capture still sees the old buffer, so skip it
      S_WAIT: begin
        if (in_valid && !popped_q) begin
          emit_s      = 1'b1;
          cur_row_s   = INDEX_WIDTH'(0);
          cur_word_s  = DIM_WIDTH'(0);
          cur_rows_s  = rows_new_s;
          src_s       = in_buffer;
          rows_this_d = rows_new_s;
          shadow_d    = in_buffer;
          popped_d    = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
        emit_s = 1'b1;
      end
      S_PAUSE: begin
        if (resume) begin
          pause_d = 1'b0;
          if (row_q == rows_this_q) begin
            state_d = S_WAIT;
          end else begin
            emit_s = 1'b1;
          end
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    off_s       = OFF_W'(BIT_WIDTH * (ARRAY_DIM * int'(cur_row_s) + 4 * int'(cur_word_s)));
    word_s      = src_s[off_s +: RAM_WIDTH];
    last_word_s = (cur_word_s == words_q - DIM_WIDTH'(1));
    last_buf_s  = last_word_s && (cur_row_s == cur_rows_s - INDEX_WIDTH'(1));
    job_end_s   = last_word_s && (rows_written_q + STREAM_WIDTH'(1) == len_q);

    if (emit_s) begin
      ram_we_d = 1'b1;
      waddr_d  = addr_q;
      dout_d   = word_s;
      if (last_word_s) begin
        word_d         = DIM_WIDTH'(0);
        row_d          = cur_row_s + INDEX_WIDTH'(1);
        rows_written_d = rows_written_q + STREAM_WIDTH'(1);
      end else begin
        word_d = cur_word_s + DIM_WIDTH'(1);
        row_d  = cur_row_s;
      end
      // A pause at a buffer boundary leaves row_q == rows_this_q, sending resume to WAIT
      if (job_end_s) begin
        state_d = S_DONE;
      end else if (addr_q == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        state_d = S_PAUSE;
        pause_d = 1'b1;
        addr_d  = base_q;
      end else if (last_buf_s) begin
        state_d = S_WAIT;
        addr_d  = addr_q + RAM_ADDR_WIDTH'(1);
      end else begin
        state_d = S_WRITE;
        addr_d  = addr_q + RAM_ADDR_WIDTH'(1);
      end
    end else begin
      ram_we_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      rows_written_q <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      words_q        <= '0;
      word_q         <= '0;
      row_q          <= '0;
      rows_this_q    <= '0;
      shadow_q       <= '0;
      waddr_q        <= '0;
      dout_q         <= '0;
      ram_we_q       <= 1'b0;
      popped_q       <= 1'b0;
      started_q      <= 1'b0;
      done_q         <= 1'b0;
      pause_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      rows_written_q <= rows_written_d;
      base_q         <= base_d;
      addr_q         <= addr_d;
      words_q        <= words_d;
      word_q         <= word_d;
      row_q          <= row_d;
      rows_this_q    <= rows_this_d;
      shadow_q       <= shadow_d;
      waddr_q        <= waddr_d;
      dout_q         <= dout_d;
      ram_we_q       <= ram_we_d;
      popped_q       <= popped_d;
      started_q      <= started_d;
      done_q         <= done_d;
      pause_q        <= pause_d;
      busy_q         <= busy_d;
    end
  end

  assign popped  = popped_q;
  assign started = started_q;
  assign busy    = busy_q;
  assign pause   = pause_q;
  assign done    = done_q;
  assign ram_we  = ram_we_q;
  assign waddr   = waddr_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_drain.sv
// Scoreboard bench for drain: a reference model queues the expected RAM writes
// per job; every observed write is popped and compared.
module tb_drain;
  localparam int BUF_W = 32 * 32 * 8;

  logic              clk = 1'b0;
  logic              resetn, start, in_valid, resume;
  logic [31:0]       out_length;
  logic [11:0]       start_waddr;
  logic [31:0]       pe_en;
  logic [BUF_W-1:0]  in_buffer;
  logic [5:0]        in_count;
  logic              popped, started, busy, pause, done, ram_we;
  logic [11:0]       waddr;
  logic [31:0]       dout;

  always #5 clk = ~clk;

  drain dut (
    .clk(clk), .resetn(resetn), .start(start), .out_length(out_length),
    .start_waddr(start_waddr), .pe_en(pe_en), .in_buffer(in_buffer),
    .in_count(in_count), .in_valid(in_valid), .resume(resume),
    .popped(popped), .started(started), .busy(busy), .pause(pause),
    .done(done), .ram_we(ram_we), .waddr(waddr), .dout(dout)
  );

  typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_pop, n_done, n_start, n_pause_rise, n_we, first_we, last_we, done_cyc;
  int exp_pop, exp_pause;
  bit pop_now, pause_prev;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int b, input int r, input int c);
    return 8'((r * 32 + c + b * 13) & 255);
  endfunction

  function automatic logic [BUF_W-1:0] make_buf(input int b);
    logic [BUF_W-1:0] bf;
    bf = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        bf[8*(32*r+c) +: 8] = byte_of(b, r, c);
    return bf;
  endfunction

  // Reference model: push every expected write of one job, in order
  task automatic build_exp(input logic [31:0] pe, input int len, input logic [11:0] sa,
                           input int c0, input int c1, input int nbuf);
    int w, rem, cnt, eff, rt;
    logic [11:0] a;
    wr_t e;
    w = 1;
    for (int g = 0; g < 8; g++) if (pe[4*g +: 4] != 4'd0) w = g + 1;
    rem = len; a = sa; exp_pop = 0; exp_pause = 0;
    for (int b = 0; b < nbuf && rem > 0; b++) begin
      cnt = (b == 0) ? c0 : c1;
      eff = (cnt == 0 || cnt > 32) ? 32 : cnt;
      rt  = (eff < rem) ? eff : rem;
      exp_pop++;
      for (int r = 0; r < rt; r++)
        for (int k = 0; k < w; k++) begin
          e.a = a;
          e.d = {byte_of(b, r, 4*k+3), byte_of(b, r, 4*k+2), byte_of(b, r, 4*k+1), byte_of(b, r, 4*k)};
          exp_q.push_back(e);
          if (a == 12'hFFF) begin
            if (!(rem == rt && r == rt - 1 && k == w - 1)) exp_pause++;
            a = sa;
          end else begin
            a = a + 12'd1;
          end
        end
      rem -= rt;
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    pop_now = popped;
    if (ram_we) begin
      n_we++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (exp_q.size() == 0) begin
        check_eq("extra_write", 64'(ram_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("waddr", 64'(waddr), 64'(e.a));
        check_eq("dout", 64'(dout), 64'(e.d));
      end
    end
    if (popped) n_pop++;
    if (started) n_start++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (pause && !pause_prev) n_pause_rise++;
    pause_prev = pause;
  endtask

  task automatic run_job(input logic [31:0] pe, input int len, input logic [11:0] sa,
                         input int c0, input int c1, input int nbuf, input bit restart);
    int bi;
    build_exp(pe, len, sa, c0, c1, nbuf);
    n_pop = 0; n_done = 0; n_start = 0; n_pause_rise = 0; n_we = 0;
    first_we = -1; last_we = -1; done_cyc = -1; pause_prev = 1'b0; bi = 0;
    pe_en = pe; out_length = 32'(len); start_waddr = sa;
    in_count = 6'(c0); in_buffer = make_buf(0); in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'(1));
    for (int i = 0; i < 2000 && n_done == 0; i++) begin
      start = (restart && i == 4) ? 1'b1 : 1'b0;
      tick();
      start = 1'b0;
      if (pop_now) begin
        bi++;
        if (bi < nbuf) begin
          in_count = 6'(c1); in_buffer = make_buf(bi);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (pause) begin
        for (int h = 0; h < 5; h++) begin
          tick();
          check_eq("pause_hold_we", 64'(ram_we), 64'(0));
          check_eq("pause_hold", 64'(pause), 64'(1));
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check_eq("resume_we", 64'(ram_we), 64'(1));
        check_eq("pause_cleared", 64'(pause), 64'(0));
      end
    end
    in_valid = 1'b0;
    check_eq("done_count", 64'(n_done), 64'(1));
    check_eq("busy_at_done", 64'(busy), 64'(0));
    check_eq("missing_writes", 64'(exp_q.size()), 64'(0));
    check_eq("popped_count", 64'(n_pop), 64'(exp_pop));
    check_eq("started_count", 64'(n_start), 64'(1));
    check_eq("pause_count", 64'(n_pause_rise), 64'(exp_pause));
    if (n_we > 0) check_eq("done_latency", 64'(done_cyc), 64'(last_we + 1));
    if (n_we > 0 && exp_pause == 0 && exp_pop == 1)
      check_eq("back_to_back", 64'(last_we - first_we + 1), 64'(n_we));
    tick();
    check_eq("done_pulse", 64'(done), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; resume = 1'b0;
    out_length = '0; start_waddr = '0; pe_en = '0; in_buffer = '0; in_count = '0;
    #12;
    check_eq("rst_ram_we", 64'(ram_we), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_pause", 64'(pause), 64'(0));
    check_eq("rst_outs", 64'({popped, started, done, waddr, dout}), 64'(0));
    @(negedge clk); resetn = 1'b1;
    tick();

    run_job(32'hFFFF_FFFF, 2, 12'h010, 2, 0, 1, 1'b0);
    run_job(32'h0000_0030, 3, 12'h000, 2, 5, 2, 1'b0);
    run_job(32'h8000_0000, 1, 12'hFFC, 1, 0, 1, 1'b0);
    run_job(32'hFFFF_FFFF, 0, 12'h020, 2, 0, 1, 1'b0);
    check_eq("len0_no_writes", 64'(n_we), 64'(0));
    run_job(32'hFFFF_FFFF, 2, 12'h010, 2, 0, 1, 1'b1);
    check_eq("restart_ignored_writes", 64'(n_we), 64'(16));

    // Asynchronous reset in the middle of a write burst
    build_exp(32'hFFFF_FFFF, 2, 12'h010, 2, 0, 1);
    pe_en = 32'hFFFF_FFFF; out_length = 32'd2; start_waddr = 12'h010;
    in_count = 6'd2; in_buffer = make_buf(0); in_valid = 1'b1; first_we = -1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check_eq("mid_write_we", 64'(ram_we), 64'(1));
    #2 resetn = 1'b0;
    #1;
    check_eq("async_rst_we", 64'(ram_we), 64'(0));
    check_eq("async_rst_busy", 64'(busy), 64'(0));
    check_eq("async_rst_pause", 64'(pause), 64'(0));
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk); resetn = 1'b1;
    tick();
    run_job(32'hFFFF_FFFF, 2, 12'h010, 2, 0, 1, 1'b0);

    run_job(32'h0000_0001, 40, 12'h100, 0, 0, 2, 1'b0);
    check_eq("len40_writes", 64'(n_we), 64'(40));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
